// File: rtl/cv32e40p_ft_replica_monitor.sv
// Per-replica health tracker fed by the TMR voter mismatch flags.
// Leaky saturating error counters, HEALTHY/SUSPECT/FAULTY FSMs, fault interrupt and sticky uncorrectable flag.
module cv32e40p_ft_replica_monitor #(
    parameter int unsigned N            = 3,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned THRESHOLD    = 16,
    parameter int unsigned DECAY_PERIOD = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_i,
    input  logic [N-1:0]       err_i,
    input  logic               clear_i,
    output logic [N-1:0]       suspect_o,
    output logic [N-1:0]       faulty_o,
    output logic [N*CNT_W-1:0] err_cnt_o,
    output logic               fault_irq_o,
    output logic               uncorrectable_o
);

    localparam int unsigned TMR_W = $clog2(DECAY_PERIOD);
    localparam int unsigned PC_W  = $clog2(N + 2);

    localparam logic [1:0] S_HEALTHY = 2'd0;
    localparam logic [1:0] S_SUSPECT = 2'd1;
    localparam logic [1:0] S_FAULTY  = 2'd2;

    localparam logic [CNT_W-1:0] THR      = CNT_W'(THRESHOLD);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DECAY_PERIOD - 1);

    logic [N-1:0][1:0]       state_q, state_d;
    logic [N-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic [N-1:0]            suspect_q, suspect_d;
    logic [N-1:0]            faulty_q, faulty_d;
    logic                    irq_q, irq_d;
    logic                    unc_q, unc_d;

    logic                    tick;
    logic [N-1:0]            eff;
    logic [PC_W-1:0]         flag_cnt;

    // Flags from replicas already declared FAULTY no longer count
    assign tick = (timer_q == TMR_LAST);
    assign eff  = {N{valid_i}} & err_i & ~faulty_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= '0;
            cnt_q     <= '0;
            timer_q   <= '0;
            suspect_q <= '0;
            faulty_q  <= '0;
            irq_q     <= 1'b0;
            unc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timer_q   <= timer_d;
            suspect_q <= suspect_d;
            faulty_q  <= faulty_d;
            irq_q     <= irq_d;
            unc_q     <= unc_d;
        end
    end

    // Next state: clear beats increment, increment beats decay
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        timer_d = tick ? '0 : timer_q + TMR_W'(1);
        if (clear_i) begin
            timer_d = '0;
            state_d = '0;
            cnt_d   = '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                case (state_q[k])
                    S_HEALTHY: begin
                        if (eff[k]) begin
                            cnt_d[k]   = CNT_W'(1);
                            state_d[k] = (THRESHOLD == 1) ? S_FAULTY : S_SUSPECT;
                        end
                    end
                    S_SUSPECT: begin
                        if (eff[k]) begin
                            cnt_d[k] = cnt_q[k] + CNT_W'(1);
                            if (cnt_d[k] == THR) begin
                                state_d[k] = S_FAULTY;
                            end
                        end else if (tick) begin
                            cnt_d[k] = cnt_q[k] - CNT_W'(1);
                            if (cnt_d[k] == '0) begin
                                state_d[k] = S_HEALTHY;
                            end
                        end
                    end
                    S_FAULTY: begin
                        cnt_d[k] = THR;
                    end
                    default: begin
                        state_d[k] = S_HEALTHY;
                        cnt_d[k]   = '0;
                    end
                endcase
            end
        end
    end

    // Output decode, taken from next state so the outputs leave flops directly
    always_comb begin
        suspect_d = '0;
        faulty_d  = '0;
        flag_cnt  = '0;
        for (int k = 0; k < N; k++) begin
            suspect_d[k] = (state_d[k] == S_SUSPECT);
            faulty_d[k]  = (state_d[k] == S_FAULTY);
            flag_cnt     = flag_cnt + PC_W'(err_i[k] & ~faulty_q[k]);
        end
        irq_d = |(faulty_d & ~faulty_q);
        unc_d = clear_i ? 1'b0 : (unc_q | (valid_i & (flag_cnt >= PC_W'(2))));
    end

    assign suspect_o       = suspect_q;
    assign faulty_o        = faulty_q;
    assign err_cnt_o       = cnt_q;
    assign fault_irq_o     = irq_q;
    assign uncorrectable_o = unc_q;

endmodule

// File: tb/tb_cv32e40p_ft_replica_monitor.sv
// Directed bench for cv32e40p_ft_replica_monitor with hand-computed expectations.
module tb_cv32e40p_ft_replica_monitor;

    localparam int DP = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic [2:0]  err_i;
    logic        clear_i;
    logic [2:0]  suspect_o;
    logic [2:0]  faulty_o;
    logic [23:0] err_cnt_o;
    logic        fault_irq_o;
    logic        uncorrectable_o;

    int n_checks = 0;
    int n_fail   = 0;
    int tb_tmr   = 0;

    cv32e40p_ft_replica_monitor dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .valid_i         (valid_i),
        .err_i           (err_i),
        .clear_i         (clear_i),
        .suspect_o       (suspect_o),
        .faulty_o        (faulty_o),
        .err_cnt_o       (err_cnt_o),
        .fault_irq_o     (fault_irq_o),
        .uncorrectable_o (uncorrectable_o)
    );

    always #5 clk = ~clk;

    // Reference phase of the decay timer, to place stimulus on tick cycles
    always @(posedge clk) begin
        if (!rst_n || clear_i) tb_tmr <= 0;
        else                   tb_tmr <= (tb_tmr == DP - 1) ? 0 : tb_tmr + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cnt(input int k);
        return 32'(err_cnt_o[k*8 +: 8]);
    endfunction

    // Drive inputs at a falling edge and return at the next one, after the update
    task automatic cyc(input logic v, input logic [2:0] e, input logic c);
        valid_i = v;
        err_i   = e;
        clear_i = c;
        @(negedge clk);
    endtask

    task automatic wait_ticks(input int n);
        valid_i = 1'b0;
        err_i   = 3'b000;
        clear_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            while (tb_tmr != DP - 1) @(negedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        valid_i = 1'b0;
        err_i   = 3'b000;
        clear_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_suspect", 32'(suspect_o), 0);
        chk("rst_faulty",  32'(faulty_o), 0);
        chk("rst_cnt",     32'(err_cnt_o), 0);
        chk("rst_irq",     32'(fault_irq_o), 0);
        chk("rst_unc",     32'(uncorrectable_o), 0);
        rst_n = 1'b1;

        // Five errors on replica 0
        for (int i = 0; i < 5; i++) cyc(1'b1, 3'b001, 1'b0);
        chk("five_cnt0",    cnt(0), 5);
        chk("five_cnt1",    cnt(1), 0);
        chk("five_cnt2",    cnt(2), 0);
        chk("five_suspect", 32'(suspect_o), 32'b001);

        // Leaky decay
        wait_ticks(3);
        chk("decay3_cnt0",    cnt(0), 2);
        chk("decay3_suspect", 32'(suspect_o), 32'b001);
        wait_ticks(2);
        chk("decay5_cnt0",    cnt(0), 0);
        chk("decay5_suspect", 32'(suspect_o), 0);

        // Threshold on replica 1
        for (int i = 0; i < 15; i++) cyc(1'b1, 3'b010, 1'b0);
        chk("thr15_cnt1",   cnt(1), 15);
        chk("thr15_faulty", 32'(faulty_o), 0);
        cyc(1'b1, 3'b010, 1'b0);
        chk("thr16_faulty",  32'(faulty_o), 32'b010);
        chk("thr16_irq",     32'(fault_irq_o), 1);
        chk("thr16_cnt1",    cnt(1), 16);
        chk("thr16_suspect", 32'(suspect_o), 0);
        cyc(1'b1, 3'b010, 1'b0);
        chk("thr17_irq",  32'(fault_irq_o), 0);
        chk("thr17_cnt1", cnt(1), 16);

        // Clear beats a simultaneous event that would otherwise be uncorrectable
        cyc(1'b1, 3'b111, 1'b1);
        chk("clr_cnt",     32'(err_cnt_o), 0);
        chk("clr_faulty",  32'(faulty_o), 0);
        chk("clr_suspect", 32'(suspect_o), 0);
        chk("clr_unc",     32'(uncorrectable_o), 0);
        chk("clr_irq",     32'(fault_irq_o), 0);

        // Increment wins over decay on the tick cycle
        for (int i = 0; i < 3; i++) cyc(1'b1, 3'b100, 1'b0);
        chk("sim_cnt2_pre", cnt(2), 3);
        valid_i = 1'b0;
        err_i   = 3'b000;
        while (tb_tmr != DP - 1) @(negedge clk);
        cyc(1'b1, 3'b100, 1'b0);
        chk("sim_cnt2_tick", cnt(2), 4);

        // Two replicas flagged together: uncorrectable, then joint fault
        cyc(1'b1, 3'b011, 1'b0);
        chk("unc_set",  32'(uncorrectable_o), 1);
        chk("unc_cnt0", cnt(0), 1);
        chk("unc_cnt1", cnt(1), 1);
        for (int i = 0; i < 14; i++) cyc(1'b1, 3'b011, 1'b0);
        chk("joint15_faulty", 32'(faulty_o), 0);
        chk("joint15_irq",    32'(fault_irq_o), 0);
        cyc(1'b1, 3'b011, 1'b0);
        chk("joint16_faulty", 32'(faulty_o), 32'b011);
        chk("joint16_irq",    32'(fault_irq_o), 1);
        chk("joint16_cnt0",   cnt(0), 16);
        chk("joint16_cnt1",   cnt(1), 16);
        cyc(1'b0, 3'b000, 1'b0);
        chk("joint_irq_drop", 32'(fault_irq_o), 0);
        chk("unc_sticky",     32'(uncorrectable_o), 1);
        cyc(1'b0, 3'b000, 1'b1);
        chk("unc_cleared", 32'(uncorrectable_o), 0);

        // Flag from a FAULTY replica does not make an event uncorrectable
        for (int i = 0; i < 16; i++) cyc(1'b1, 3'b001, 1'b0);
        chk("r0_faulty", 32'(faulty_o), 32'b001);
        cyc(1'b1, 3'b011, 1'b0);
        chk("r0f_unc",  32'(uncorrectable_o), 0);
        chk("r0f_cnt1", cnt(1), 1);
        chk("r0f_cnt0", cnt(0), 16);

        // valid_i low masks err_i
        cyc(1'b0, 3'b111, 1'b0);
        chk("novalid_cnt1", cnt(1), 1);
        chk("novalid_cnt2", cnt(2), 0);
        chk("novalid_unc",  32'(uncorrectable_o), 0);

        // Reset mid-count
        cyc(1'b1, 3'b010, 1'b0);
        cyc(1'b1, 3'b010, 1'b0);
        chk("pre_rst_cnt1", cnt(1), 3);
        rst_n = 1'b0;
        cyc(1'b1, 3'b010, 1'b0);
        chk("midrst_cnt",    32'(err_cnt_o), 0);
        chk("midrst_faulty", 32'(faulty_o), 0);
        rst_n = 1'b1;
        cyc(1'b0, 3'b000, 1'b0);
        chk("postrst_cnt", 32'(err_cnt_o), 0);
        cyc(1'b1, 3'b100, 1'b0);
        chk("postrst_cnt2",    cnt(2), 1);
        chk("postrst_suspect", 32'(suspect_o), 32'b100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
